// File: rtl/fft_pkg.sv
// Shared FFT definitions: sample widths, frame size, complex sample type and
// the 3-bit bit-reversal used to order stage-0 butterfly inputs.
package fft_pkg;

    localparam int unsigned DATA_W = 16;
    localparam int unsigned N      = 8;
    localparam int unsigned LOG2N  = 3;

    typedef struct packed {
        logic [DATA_W-1:0] re;
        logic [DATA_W-1:0] im;
    } cplx_t;

    function automatic logic [LOG2N-1:0] bitrev3(input logic [LOG2N-1:0] k);
        return {k[0], k[1], k[2]};
    endfunction

endpackage

// File: rtl/fft_frame_bank.sv
// One frame of complex samples: single indexed write port, all entries
// readable in parallel. Contents are not reset; validity is tracked outside.
module fft_frame_bank
    import fft_pkg::*;
(
    input  logic                   clk,
    input  logic                   i_we,
    input  logic [LOG2N-1:0]       i_widx,
    input  cplx_t                  i_wdata,
    output cplx_t [N-1:0]          o_rdata
);

    cplx_t [N-1:0] r_mem;

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_widx] <= i_wdata;
        end
    end

    assign o_rdata = r_mem;

endmodule

// File: rtl/fft_input_loader.sv
// Ping-pong frame loader: collects 8 streamed complex samples per frame and
// presents them in bit-reversed slot order to the stage-0 butterfly array.
module fft_input_loader
    import fft_pkg::*;
#(
    parameter int unsigned DATA_W = fft_pkg::DATA_W,
    parameter int unsigned N      = fft_pkg::N
)
(
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [DATA_W-1:0]   in_real,
    input  logic [DATA_W-1:0]   in_imag,
    input  logic                in_last,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [N*DATA_W-1:0] out_real,
    output logic [N*DATA_W-1:0] out_imag,
    output logic                frame_err
);

    logic [1:0]       r_full;
    logic             r_wr_bank;
    logic             r_rd_bank;
    logic [LOG2N-1:0] r_wr_idx;
    logic             r_frame_err;

    logic             w_acc;
    logic             w_rel;
    logic             w_last_idx;
    logic             w_drop;
    logic             w_we0;
    logic             w_we1;
    cplx_t            w_wr_data;
    cplx_t [N-1:0]    w_rd0;
    cplx_t [N-1:0]    w_rd1;
    cplx_t [N-1:0]    w_rd;

    assign in_ready   = ~r_full[r_wr_bank];
    assign out_valid  = r_full[r_rd_bank];
    assign frame_err  = r_frame_err;

    assign w_acc      = in_valid & in_ready;
    assign w_rel      = out_valid & out_ready;
    assign w_last_idx = (r_wr_idx == LOG2N'(N - 1));
    // An early in_last aborts the frame and the beat carrying it is not stored
    assign w_drop     = in_last & ~w_last_idx;

    assign w_wr_data.re = in_real;
    assign w_wr_data.im = in_imag;
    assign w_we0        = w_acc & ~w_drop & ~r_wr_bank;
    assign w_we1        = w_acc & ~w_drop &  r_wr_bank;

    fft_frame_bank u_bank0 (
        .clk     (clk),
        .i_we    (w_we0),
        .i_widx  (r_wr_idx),
        .i_wdata (w_wr_data),
        .o_rdata (w_rd0)
    );

    fft_frame_bank u_bank1 (
        .clk     (clk),
        .i_we    (w_we1),
        .i_widx  (r_wr_idx),
        .i_wdata (w_wr_data),
        .o_rdata (w_rd1)
    );

    assign w_rd = r_rd_bank ? w_rd1 : w_rd0;

    // Slot k carries sample bitrev3(k) so adjacent slots pair up per butterfly
    always_comb begin
        out_real = '0;
        out_imag = '0;
        for (int unsigned k = 0; k < N; k++) begin
            out_real[k*DATA_W +: DATA_W] = w_rd[bitrev3(LOG2N'(k))].re;
            out_imag[k*DATA_W +: DATA_W] = w_rd[bitrev3(LOG2N'(k))].im;
        end
    end

    // Completion and release never target the same bank: one needs it empty, the other full
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_full      <= '0;
            r_wr_bank   <= 1'b0;
            r_rd_bank   <= 1'b0;
            r_wr_idx    <= '0;
            r_frame_err <= 1'b0;
        end else begin
            r_frame_err <= 1'b0;
            if (w_rel) begin
                r_full[r_rd_bank] <= 1'b0;
                r_rd_bank         <= ~r_rd_bank;
            end
            if (w_acc) begin
                if (w_last_idx) begin
                    r_full[r_wr_bank] <= 1'b1;
                    r_wr_bank         <= ~r_wr_bank;
                    r_wr_idx          <= '0;
                    r_frame_err       <= ~in_last;
                end else if (in_last) begin
                    r_wr_idx          <= '0;
                    r_frame_err       <= 1'b1;
                end else begin
                    r_wr_idx          <= r_wr_idx + LOG2N'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_fft_input_loader.sv
// Scoreboard bench for fft_input_loader: stimulus pushes expected frames,
// a negedge monitor pops and compares on every output handshake.
module tb_fft_input_loader;

    localparam int unsigned DW = 16;
    localparam int unsigned NP = 8;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [DW-1:0]    in_real;
    logic [DW-1:0]    in_imag;
    logic             in_last;
    logic             out_valid;
    logic             out_ready;
    logic [NP*DW-1:0] out_real;
    logic [NP*DW-1:0] out_imag;
    logic             frame_err;

    always #5 clk = ~clk;

    fft_input_loader dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_real   (in_real),
        .in_imag   (in_imag),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_real  (out_real),
        .out_imag  (out_imag),
        .frame_err (frame_err)
    );

    typedef struct {
        logic [NP*DW-1:0] re;
        logic [NP*DW-1:0] im;
    } frame_t;

    frame_t      exp_q[$];
    int          n_chk   = 0;
    int          n_pass  = 0;
    int          exp_err = 0;
    int          seen_err = 0;
    int          n_hs    = 0;
    int          n_push  = 0;
    int          cyc     = 0;
    logic [DW-1:0] m_re[NP];
    logic [DW-1:0] m_im[NP];
    int          m_idx   = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [NP*DW-1:0] act, input logic [NP*DW-1:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    endtask

    // Reference frame assembly: slot k expects sample with index bit-reversed k
    task automatic model_accept(input logic [DW-1:0] re, input logic [DW-1:0] im, input logic last);
        frame_t f;
        logic [2:0] kb;
        logic [2:0] src;
        if (last && m_idx != 7) begin
            exp_err++;
            m_idx = 0;
        end else begin
            m_re[m_idx] = re;
            m_im[m_idx] = im;
            if (m_idx == 7) begin
                if (!last) exp_err++;
                for (int k = 0; k < 8; k++) begin
                    kb  = 3'(k);
                    src = {kb[0], kb[1], kb[2]};
                    f.re[k*DW +: DW] = m_re[src];
                    f.im[k*DW +: DW] = m_im[src];
                end
                exp_q.push_back(f);
                n_push++;
                m_idx = 0;
            end else begin
                m_idx++;
            end
        end
    endtask

    task automatic send(input logic [DW-1:0] re, input logic [DW-1:0] im, input logic last);
        logic acc;
        int   w;
        acc = 1'b0;
        w   = 0;
        in_valid = 1'b1;
        in_real  = re;
        in_imag  = im;
        in_last  = last;
        while (!acc && w <= 500) begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
            if (!acc) w++;
        end
        if (acc) model_accept(re, im, last);
        else check("send_timeout", 128'(0), 128'(1));
    endtask

    task automatic send_frame(input int base, input logic last8);
        logic [DW-1:0] v;
        for (int i = 0; i < 8; i++) begin
            v = DW'(base + i);
            send(v, -v, (i == 7) ? last8 : 1'b0);
        end
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        in_last  = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Monitor: compares every presented-and-consumed frame against the scoreboard
    always @(negedge clk) begin
        frame_t f;
        if (rst_n) begin
            if (frame_err) seen_err++;
            if (out_valid && out_ready) begin
                n_hs++;
                if (exp_q.size() == 0) begin
                    check("unexpected_frame", 128'(1), 128'(0));
                end else begin
                    f = exp_q.pop_front();
                    check("frame_real", out_real, f.re);
                    check("frame_imag", out_imag, f.im);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [NP*DW-1:0] frozen;
        int hs0;
        int t0;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_real   = '0;
        in_imag   = '0;
        in_last   = 1'b0;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        @(negedge clk);
        check("reset_out_valid", 128'(out_valid), 128'(0));
        check("reset_in_ready",  128'(in_ready),  128'(1));
        check("reset_frame_err", 128'(frame_err), 128'(0));
        @(posedge clk); #1;

        // Basic frame with hand-computed bit-reversed layout
        send_frame(0, 1'b1);
        in_valid = 1'b0;
        in_last  = 1'b0;
        @(negedge clk);
        check("latency_out_valid", 128'(out_valid), 128'(1));
        check("basic_real_hand", out_real,
              {16'd7, 16'd3, 16'd5, 16'd1, 16'd6, 16'd2, 16'd4, 16'd0});
        check("basic_imag_hand", out_imag,
              {16'hFFF9, 16'hFFFD, 16'hFFFB, 16'hFFFF, 16'hFFFA, 16'hFFFE, 16'hFFFC, 16'h0000});
        idle(3);

        // Backpressure: both banks fill, third frame waits for release
        out_ready = 1'b0;
        send_frame(16'h100, 1'b1);
        send_frame(16'h200, 1'b1);
        frozen = exp_q[0].re;
        fork
            send_frame(16'h300, 1'b1);
            begin
                repeat (2) @(negedge clk);
                check("bp_in_ready_low", 128'(in_ready), 128'(0));
                check("bp_out_valid",    128'(out_valid), 128'(1));
                check("bp_frame1_held",  out_real, frozen);
                repeat (4) @(negedge clk);
                check("bp_still_low",    128'(in_ready), 128'(0));
                check("bp_frame1_still", out_real, frozen);
                @(posedge clk);
                #1 out_ready = 1'b1;
                @(posedge clk);
                @(negedge clk);
                check("bp_ready_after_release", 128'(in_ready), 128'(1));
            end
        join
        idle(4);

        // Ten frames streamed with no stalls
        hs0 = n_hs;
        t0  = cyc;
        for (int f = 0; f < 10; f++) send_frame(16'h1000 + f * 16, 1'b1);
        check("stream_cycles", 128'(cyc - t0), 128'(80));
        idle(3);
        check("stream_handshakes", 128'(n_hs - hs0), 128'(10));

        // Early in_last on beat 5 aborts the frame
        for (int i = 0; i < 4; i++) send(DW'(16'h400 + i), DW'(16'h0400 + i), 1'b0);
        send(16'h404, 16'h0404, 1'b1);
        in_valid = 1'b0;
        in_last  = 1'b0;
        @(negedge clk);
        check("early_last_err",     128'(frame_err), 128'(1));
        check("early_last_novalid", 128'(out_valid), 128'(0));
        @(negedge clk);
        check("early_last_err_pulse", 128'(frame_err), 128'(0));
        @(posedge clk); #1;
        send_frame(16'h500, 1'b1);
        idle(3);

        // Missing in_last: error pulse yet the frame is delivered
        send_frame(16'h600, 1'b0);
        in_valid = 1'b0;
        @(negedge clk);
        check("missing_last_err",   128'(frame_err), 128'(1));
        check("missing_last_valid", 128'(out_valid), 128'(1));
        idle(3);

        // Reset mid-frame discards the partial frame
        for (int i = 0; i < 4; i++) send(DW'(16'h700 + i), DW'(16'h0700 + i), 1'b0);
        in_valid = 1'b0;
        rst_n    = 1'b0;
        m_idx    = 0;
        exp_q.delete();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check("rst_out_valid", 128'(out_valid), 128'(0));
        check("rst_in_ready",  128'(in_ready),  128'(1));
        check("rst_frame_err", 128'(frame_err), 128'(0));
        idle(10);
        send_frame(16'h800, 1'b1);
        idle(4);

        check("queue_drained", 128'(exp_q.size()), 128'(0));
        check("frame_err_count", 128'(seen_err), 128'(exp_err));
        check("handshake_count", 128'(n_hs), 128'(n_push));

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/fft_input_loader.md
FFT_INPUT_LOADER -- requirements
Module: fft_input_loader

Interface
REQ-001 The block SHALL use these parameters: DATA_W, default 16, width of each real/imag component; N, default 8, points per frame (fixed at 8 in this revision).
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1 bit: reset, synchronous and active-low.
REQ-004 The block SHALL have port in_valid, input, 1 bit: an input sample is presented.
REQ-005 The block SHALL have port in_ready, output, 1 bit: the block can accept an input sample this cycle.
REQ-006 The block SHALL have port in_real, input, DATA_W bits: real part of the sample, two's complement.
REQ-007 The block SHALL have port in_imag, input, DATA_W bits: imaginary part of the sample, two's complement.
REQ-008 The block SHALL have port in_last, input, 1 bit: marks the 8th (final) sample of a frame.
REQ-009 The block SHALL have port out_valid, output, 1 bit: a complete frame is presented to the stage-0 butterfly array.
REQ-010 The block SHALL have port out_ready, input, 1 bit: stage 0 consumes the presented frame.
REQ-011 The block SHALL have port out_real, output, N*DATA_W bits: slot k occupies bits [k*DATA_W +: DATA_W].
REQ-012 The block SHALL have port out_imag, output, N*DATA_W bits, with the same slot layout as out_real.
REQ-013 The block SHALL have port frame_err, output, 1 bit: one-cycle pulse on a framing violation.

Function
REQ-014 An input beat SHALL be accepted when in_valid and in_ready are both 1; there SHALL be no acceptance otherwise.
REQ-015 Two frame banks (ping-pong) SHALL be provided, each with 8 complex entries and a full flag; a write-bank pointer, a read-bank pointer and a 3-bit write index SHALL be maintained.
REQ-016 in_ready SHALL equal NOT full[write bank]; it SHALL not depend combinationally on in_valid.
REQ-017 An accepted beat SHALL be written to entry write_index of the write bank, and write_index SHALL increment.
REQ-018 An accepted beat at write_index 7 SHALL complete the frame: the next cycle sets full of that bank, toggles the write-bank pointer and wraps write_index to 0.
REQ-019 out_valid SHALL equal full[read bank], and it SHALL go to 1 on the cycle after the 8th beat is accepted (latency 1).
REQ-020 Output slot k SHALL carry sample bitrev3(k); slot order SHALL be samples 0,4,2,6,1,5,3,7, so adjacent slot pairs (0,1),(2,3),(4,5),(6,7) feed the stage-0 butterflies directly.
REQ-021 out_real and out_imag SHALL be driven from bank registers, hold stable while out_valid is 1 and out_ready is 0, and pass data without arithmetic or width change.
REQ-022 When out_valid and out_ready are both 1, full[read bank] SHALL clear and the read-bank pointer SHALL toggle on that edge.
REQ-023 If a frame completes and a frame is released in the same cycle, both updates SHALL occur; sustained throughput SHALL be 1 sample/cycle when out_ready is held at 1.
REQ-024 When both banks are full, in_ready SHALL be 0 until a release; the cycle after a release, in_ready SHALL be 1.
REQ-025 If in_last is 1 on an accepted beat with write_index not equal to 7, frame_err SHALL pulse the next cycle, the partial frame SHALL be discarded (write_index goes to 0, bank not marked full) and the beat SHALL itself be dropped.
REQ-026 If in_last is 0 on an accepted beat at write_index 7, the frame SHALL complete normally and frame_err SHALL pulse the next cycle.
REQ-027 frame_err SHALL be 0 in all other cycles.

Reset
REQ-028 While rst_n is 0 at a clock edge, the block SHALL set: both full flags to 0, both bank pointers to 0, write_index to 0, out_valid to 0, in_ready to 1 on the following cycle, and frame_err to 0.
REQ-029 Bank data SHALL not require reset; out_real and out_imag SHALL be don't-care while out_valid is 0.
REQ-030 Reset asserted mid-frame or with frames pending SHALL discard all buffered data; no partial frame SHALL survive reset.

Structure
REQ-031 Package fft_pkg SHALL hold DATA_W, N, LOG2N=3, the complex sample struct and the bitrev3 function; stage-0 and later stages SHALL share this package.
REQ-032 One sub-module, fft_frame_bank (8-entry complex register file with write enable/index and parallel read), SHALL be instantiated twice.
REQ-033 The total implementation SHALL be 120-400 lines of RTL.

Verification
REQ-034 Reset, then feed samples real=0..7, imag=-(0..7) with in_last on the 8th beat and out_ready held at 1 -> out_valid=1 one cycle later; real slots = 0,4,2,6,1,5,3,7; imag slots are the negated values.
REQ-035 Feed three back-to-back frames with out_ready=0 -> in_ready drops to 0 after beat 16; outputs stay frozen on frame 1; raising out_ready presents frames 1 then 2, and frame 3 loads without loss.
REQ-036 Stream 10 continuous frames with in_valid=1 and out_ready=1 -> in_ready stays 1 throughout, 10 out_valid handshakes occur, and every frame is bit-reversed correctly.
REQ-037 Assert in_last on beat 5 -> frame_err pulses 1 cycle and no out_valid; the next 8 clean beats yield a correct frame.
REQ-038 Omit in_last on beat 8 -> frame_err pulses and the frame is still output; assert rst_n=0 after 4 beats of the next frame -> out_valid=0 and in_ready=1 after reset, and no stale frame appears.
